popcount_window_acc: RTL and testbench

//  Multi-cycle, polarity-programmable population counter with window accumulation.

---
 rtl/popcount_window_acc.sv | 94 +++++++++
 tb/tb_popcount_window_acc.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/popcount_window_acc.sv
// popcount_window_acc: polarity-masked multi-cycle popcount summed over WINDOW samples; define POPCNT_THRESH_EN for the threshold flag oOver
module popcount_window_acc #(
  parameter int WIDTH = 8,
  parameter int LANES = 2,
  parameter int WINDOW = 4,
  localparam int CNT_W = $clog2(WIDTH*WINDOW+1)
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iClear,
  input  logic [WIDTH-1:0] iData,
  input  logic [WIDTH-1:0] iPolMask,
  input  logic             iValid,
  output logic             oReady,
  output logic [CNT_W-1:0] oCount,
  output logic             oValid,
`ifdef POPCNT_THRESH_EN
  input  logic [CNT_W-1:0] iThresh,
  output logic             oOver,
`endif
  input  logic             iReady
);
  localparam int NCH = WIDTH/LANES;
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
  localparam int IW = WINDOW > 1 ? $clog2(WINDOW) : 1;
  localparam int PW = $clog2(LANES+1);
  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0] chunk;
  logic [IW-1:0] idx;
  logic [CNT_W-1:0] acc, sum;
  logic [PW-1:0] psum;
  logic last_chunk, last_sample, finish;
  assign oReady = (state == IDLE) & ~iClear;
  assign last_chunk = chunk == CW'(NCH-1);
  assign last_sample = idx == IW'(WINDOW-1);
  assign finish = (state == COUNT) & last_chunk & last_sample;
  // ones in the lowest LANES bits of the shift register, added to the running total
  always_comb begin
    psum = '0;
    for (int i = 0; i < LANES; i++) psum = psum + PW'(shreg[i]);
    sum = acc + CNT_W'(psum);
  end
  // next state: clear wins over accept and output handshake
  always_comb begin
    state_n = state;
    if (iClear) state_n = IDLE;
    else if (state == IDLE && iValid) state_n = COUNT;
    else if (state == COUNT && last_chunk) state_n = last_sample ? DONE : IDLE;
    else if (state == DONE && iReady) state_n = IDLE;
  end
  // state register
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) state <= IDLE;
    else state <= state_n;
  // datapath: latch masked sample, count chunk by chunk, publish the window total
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) begin
      shreg <= '0;
      chunk <= '0;
      acc <= '0;
      idx <= '0;
      oCount <= '0;
      oValid <= 1'b0;
    end else if (iClear) begin
      acc <= '0;
      idx <= '0;
      oValid <= 1'b0;
    end else if (state == IDLE) begin
      if (iValid) begin
        shreg <= iData ^ iPolMask;
        chunk <= '0;
      end
    end else if (state == COUNT) begin
      acc <= sum;
      shreg <= shreg >> LANES;
      chunk <= chunk + CW'(1);
      if (last_chunk && last_sample) begin
        oCount <= sum;
        oValid <= 1'b1;
      end else if (last_chunk) idx <= idx + IW'(1);
    end else if (iReady) begin
      oValid <= 1'b0;
      acc <= '0;
      idx <= '0;
    end
`ifdef POPCNT_THRESH_EN
  // threshold flag captured alongside the final sum, untouched by clear
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) oOver <= 1'b0;
    else if (!iClear && finish) oOver <= sum >= iThresh;
`endif
endmodule

// File: tb/tb_popcount_window_acc.sv
// tb_popcount_window_acc: directed windows with a queued expected-total scoreboard
module tb_popcount_window_acc;
  logic iClk = 1'b0, iRst_n = 1'b0, iClear = 1'b0, iValid = 1'b0, iReady = 1'b1;
  logic [7:0] iData = '0, iPolMask = '0;
  logic oReady, oValid;
  logic [5:0] oCount;
`ifdef POPCNT_THRESH_EN
  logic [5:0] iThresh = '0;
  logic oOver;
`endif
  int n_vec = 0, n_err = 0;
  logic [5:0] exp_q[$];
  popcount_window_acc #(.WIDTH(8), .LANES(2), .WINDOW(4)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iClear(iClear), .iData(iData), .iPolMask(iPolMask),
    .iValid(iValid), .oReady(oReady), .oCount(oCount), .oValid(oValid),
`ifdef POPCNT_THRESH_EN
    .iThresh(iThresh), .oOver(oOver),
`endif
    .iReady(iReady));
  always #5 iClk = ~iClk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  // monitor: every result handshake is matched against the oldest expected total
  always @(negedge iClk)
    if (iRst_n && !iClear && oValid && iReady) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got %0d, expected none", oCount);
      end else check("result", oCount, exp_q.pop_front());
    end
  task automatic send(input logic [7:0] d, input logic [7:0] m, input bit gap, input bit fin);
    int t;
    for (t = 0; t < 100; t++) begin
      @(negedge iClk);
      if (oReady) break;
    end
    if (t == 100) check("accept_timeout", 0, 1);
    iData = d;
    iPolMask = m;
    iValid = 1'b1;
    @(posedge iClk);
    #1 iValid = 1'b0;
    if (gap)
      for (int k = 0; k < 5; k++) begin
        @(negedge iClk);
        check("ready_gap", oReady, (k == 4) && !fin);
        if (fin) check("valid_timing", oValid, k == 4);
      end
  endtask
  task automatic window(input logic [31:0] ds, input logic [7:0] m, input bit gap, input logic [5:0] exp, input bit push);
    if (push) exp_q.push_back(exp);
    for (int i = 0; i < 4; i++) send(ds[31-8*i -: 8], m, gap, gap && i == 3);
  endtask
  task automatic wait_valid();
    int t;
    for (t = 0; t < 20; t++) begin
      @(negedge iClk);
      if (oValid) break;
    end
    if (t == 20) check("valid_timeout", 0, 1);
  endtask
  task automatic drain();
    for (int t = 0; t < 30 && exp_q.size() != 0; t++) @(negedge iClk);
    check("pending_results", exp_q.size(), 0);
  endtask
  initial begin
    #3;
    check("rst_ready", oReady, 1);
    check("rst_valid", oValid, 0);
    check("rst_count", oCount, 0);
    repeat (2) @(negedge iClk);
    iRst_n = 1'b1;
    window(32'hFF0F0100, 8'h00, 1, 6'd13, 1);
    drain();
    window(32'h00000000, 8'hFF, 0, 6'd32, 1);
    drain();
    iReady = 1'b0;
    window(32'h3C3C3C3C, 8'hF0, 0, 6'd16, 1);
    wait_valid();
    iValid = 1'b1;
    iData = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      @(negedge iClk);
      check("hold_valid", oValid, 1);
      check("hold_count", oCount, 16);
      check("hold_ready", oReady, 0);
    end
    iValid = 1'b0;
    iReady = 1'b1;
    drain();
    window(32'h03030303, 8'h00, 0, 6'd8, 1);
    drain();
    for (int i = 0; i < 3; i++) send(8'h01, 8'h00, 0, 0);
    @(posedge iClk);
    #1 iClear = 1'b1;
    @(negedge iClk);
    check("ready_in_clear", oReady, 0);
    @(posedge iClk);
    #1 iClear = 1'b0;
    @(negedge iClk);
    check("clear_ready", oReady, 1);
    check("clear_valid", oValid, 0);
    window(32'h01010101, 8'h00, 0, 6'd4, 1);
    drain();
    send(8'h55, 8'h00, 0, 0);
    @(posedge iClk);
    #3 iRst_n = 1'b0;
    #1;
    check("rst_count_mid", oCount, 0);
    check("rst_valid_mid", oValid, 0);
    check("rst_ready_mid", oReady, 1);
    @(negedge iClk);
    iRst_n = 1'b1;
    iReady = 1'b0;
    window(32'hFF0F0100, 8'h00, 0, 6'd13, 0);
    wait_valid();
    check("done_count", oCount, 13);
    #2 iRst_n = 1'b0;
    #1;
    check("rst_count_done", oCount, 0);
    check("rst_valid_done", oValid, 0);
    @(negedge iClk);
    iRst_n = 1'b1;
    iReady = 1'b1;
    window(32'hFF0F0100, 8'h00, 1, 6'd13, 1);
    drain();
`ifdef POPCNT_THRESH_EN
    for (int j = 0; j < 2; j++) begin
      iThresh = 6'(13 + j);
      iReady = 1'b0;
      window(32'hFF0F0100, 8'h00, 0, 6'd13, 1);
      wait_valid();
      check("over", oOver, j == 0);
      iReady = 1'b1;
      drain();
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
